// File: rtl/s16_loader_pkg.sv
// Shared types and widths for the S16 boot-time program loader.
package s16_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_rx_state(input state_t s);
        return !(s inside {ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/s16_loader_csum.sv
// 8-bit running byte sum with synchronous clear and add-enable.
module s16_loader_csum
    import s16_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/s16_prog_loader.sv
// Byte-stream program loader for the S16 core; holds the core in reset until loaded.
// Optional trailing checksum byte enabled by S16_LOADER_CHECKSUM_EN.
module s16_prog_loader
    import s16_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

`ifdef S16_LOADER_CHECKSUM_EN
    localparam state_t TAIL = ST_CSUM;
`else
    localparam state_t TAIL = ST_DONE;
`endif

    state_t              state;
    state_t              state_nx;
    logic [BYTE_W-1:0]   hi_q;
    logic [COUNT_W-1:0]  left_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [COUNT_W-1:0]  cnt;
    logic                xfer;
    logic                oversize;
    logic                last_word;
    logic                csum_ok;

    assign xfer      = rx_valid & rx_ready;
    assign cnt       = {hi_q, rx_data};
    assign oversize  = 33'(cnt) > CAP;
    assign last_word = left_q == COUNT_W'(1);

`ifdef S16_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum;

    s16_loader_csum u_csum (
        .clk    (clk),
        .clr    (reset),
        .add_en (xfer && state != ST_CSUM),
        .din    (rx_data),
        .sum    (sum)
    );

    assign csum_ok = rx_data == sum;
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_CNT_HI: begin
                if (xfer) state_nx = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (xfer) begin
                    if (oversize)         state_nx = ST_ERR;
                    else if (cnt == '0)   state_nx = TAIL;
                    else                  state_nx = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) state_nx = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (xfer) state_nx = last_word ? TAIL : ST_DATA_HI;
            end
            ST_CSUM: begin
                if (xfer) state_nx = csum_ok ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_nx = ST_DONE;
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_ERR;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CNT_HI;
            hi_q       <= '0;
            left_q     <= '0;
            addr_q     <= '0;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rx_ready  <= is_rx_state(state_nx);
            cpu_reset <= state_nx != ST_DONE;
            load_done <= state_nx == ST_DONE;
            load_err  <= state_nx == ST_ERR;
            imem_we   <= 1'b0;
            if (xfer && (state == ST_CNT_HI || state == ST_DATA_HI)) begin
                hi_q <= rx_data;
            end
            if (xfer && state == ST_CNT_LO) begin
                left_q <= cnt;
            end
            if (xfer && state == ST_DATA_LO) begin
                imem_we    <= 1'b1;
                imem_addr  <= addr_q;
                imem_wdata <= {hi_q, rx_data};
                addr_q     <= addr_q + ADDR_W'(1);
                left_q     <= left_q - COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_s16_prog_loader.sv
// Directed self-checking bench for s16_prog_loader (both S16_LOADER_CHECKSUM_EN builds).
module tb_s16_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  wq_addr[$];
    logic [15:0] wq_data[$];

`ifdef S16_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    s16_prog_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL send_timeout: rx_ready=%0b required 1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] s[$], input bit gap);
        foreach (s[i]) begin
            send(s[i]);
            if (gap && i != s.size() - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b required %0b", nm, act, exp);
        end
    endtask

    task automatic check_two_writes(input string nm);
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL %s_nwrites: got %0d required 2", nm, wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 8'd0 || wq_data[0] !== 16'h1234) begin
                errors++;
                $display("FAIL %s_w0: got %h@%0d required 1234@0", nm, wq_data[0], wq_addr[0]);
            end
            checks++;
            if (wq_addr[1] !== 8'd1 || wq_data[1] !== 16'hABCD) begin
                errors++;
                $display("FAIL %s_w1: got %h@%0d required abcd@1", nm, wq_data[1], wq_addr[1]);
            end
        end
    endtask

    function automatic void base_stream(output logic [7:0] s[$], input logic [7:0] ck);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        if (CK) s.push_back(ck);
    endfunction

    task automatic test_reset();
        do_reset();
        check_bit("rst_rx_ready", rx_ready, 1'b1);
        check_bit("rst_imem_we", imem_we, 1'b0);
        checks++;
        if (imem_addr !== 8'd0 || imem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL rst_addr_data: got %h/%h required 0/0", imem_addr, imem_wdata);
        end
        check_bit("rst_cpu_reset", cpu_reset, 1'b1);
        check_bit("rst_load_done", load_done, 1'b0);
        check_bit("rst_load_err", load_err, 1'b0);
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        int c0;
        base_stream(s, 8'hC0);
        do_reset();
        c0 = cyc;
        for (int i = 0; i < s.size() - 1; i++) send(s[i]);
        check_bit("basic_pre_cpu_reset", cpu_reset, 1'b1);
        check_bit("basic_pre_done", load_done, 1'b0);
        send(s[s.size() - 1]);
        check_bit("basic_cpu_reset", cpu_reset, 1'b0);
        check_bit("basic_done", load_done, 1'b1);
        check_bit("basic_err", load_err, 1'b0);
        check_bit("basic_rx_ready", rx_ready, 1'b0);
        checks++;
        if (cyc - c0 != s.size()) begin
            errors++;
            $display("FAIL basic_cycles: got %0d required %0d", cyc - c0, s.size());
        end
        @(posedge clk); #1;
        check_two_writes("basic");
    endtask

    task automatic test_bad_csum();
        logic [7:0] s[$];
        base_stream(s, 8'hC1);
        do_reset();
        send_q(s, 1'b0);
        @(posedge clk); #1;
        check_two_writes("badck");
        check_bit("badck_err", load_err, 1'b1);
        check_bit("badck_cpu_reset", cpu_reset, 1'b1);
        check_bit("badck_rx_ready", rx_ready, 1'b0);
        check_bit("badck_done", load_done, 1'b0);
    endtask

    task automatic test_oversize();
        do_reset();
        send(8'h01);
        send(8'h01);
        check_bit("over_err", load_err, 1'b1);
        check_bit("over_rx_ready", rx_ready, 1'b0);
        check_bit("over_cpu_reset", cpu_reset, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (wq_addr.size() != 0) begin
            errors++;
            $display("FAIL over_writes: got %0d required 0", wq_addr.size());
        end
    endtask

    task automatic test_zero();
        do_reset();
        send(8'h00);
        send(8'h00);
        if (CK) begin
            check_bit("zero_pre_done", load_done, 1'b0);
            send(8'h00);
        end
        check_bit("zero_done", load_done, 1'b1);
        check_bit("zero_cpu_reset", cpu_reset, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (wq_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_writes: got %0d required 0", wq_addr.size());
        end
    endtask

    task automatic test_full_capacity();
        logic [7:0] s[$];
        int bad = 0;
        s = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            s.push_back(8'(i));
            s.push_back(~8'(i));
        end
        if (CK) s.push_back(8'h01);
        do_reset();
        send_q(s, 1'b0);
        check_bit("full_done", load_done, 1'b1);
        check_bit("full_err", load_err, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (wq_addr.size() != 256) begin
            errors++;
            $display("FAIL full_nwrites: got %0d required 256", wq_addr.size());
        end else begin
            foreach (wq_addr[i]) begin
                if (wq_addr[i] !== 8'(i) || wq_data[i] !== {8'(i), ~8'(i)}) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_content: got %0d bad writes required 0", bad);
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] s[$];
        int c0;
        base_stream(s, 8'hC0);
        do_reset();
        c0 = cyc;
        send_q(s, 1'b1);
        checks++;
        if (cyc - c0 != 2 * s.size() - 1) begin
            errors++;
            $display("FAIL tog_cycles: got %0d required %0d", cyc - c0, 2 * s.size() - 1);
        end
        check_bit("tog_done", load_done, 1'b1);
        check_bit("tog_cpu_reset", cpu_reset, 1'b0);
        @(posedge clk); #1;
        check_two_writes("tog");
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[$];
        base_stream(s, 8'hC0);
        do_reset();
        send(8'h00);
        send(8'h02);
        send(8'h12);
        do_reset();
        check_bit("mid_rx_ready", rx_ready, 1'b1);
        send_q(s, 1'b0);
        @(posedge clk); #1;
        check_two_writes("mid");
        check_bit("mid_done", load_done, 1'b1);
        check_bit("mid_err", load_err, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        if (CK) test_bad_csum();
        test_oversize();
        test_zero();
        test_full_capacity();
        test_toggle();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s16_prog_loader.md
# s16_prog_loader

Boot-time program loader sitting directly upstream of the S16 CPU core. It receives a byte stream over a valid/ready interface and assembles it into 16-bit instruction words. Each word is written into the CPU's instruction memory. The loader holds the core in reset until a complete, valid image is loaded, then releases it.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  16  instruction word for the write.
- cpu_reset  out  1  drives the S16 core's reset; high while loading.
- load_done  out  1  image accepted; sticky until reset.
- load_err  out  1  image rejected; sticky until reset.

## Operation
- Stream format: count_hi, count_lo (N = 16-bit word count, big-endian), then N words as hi byte then lo byte, then (macro-dependent) one checksum byte.
- A byte transfers on a rising edge with rx_valid & rx_ready.
- FSM states:
  - CNT_HI → CNT_LO.
  - CNT_LO:
    - N > 2^ADDR_W → ERR.
    - N == 0 → CSUM (or DONE without the macro).
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO.
  - DATA_LO: writes the word, then → DATA_HI; after the Nth word → CSUM (or DONE without the macro).
  - CSUM: byte matches → DONE, mismatch → ERR.
  - DONE and ERR are terminal until reset.
- rx_ready = 1 in CNT_HI/CNT_LO/DATA_HI/DATA_LO/CSUM, 0 in DONE/ERR. Bytes offered in DONE/ERR are never consumed.
- Word address starts at 0 and increments by 1 after each write. N == 2^ADDR_W is legal; the address wraps to 0 after the final write and is never reused.
- Reset outputs:
  - rx_ready = 1
  - imem_we = 0
  - imem_addr = 0
  - imem_wdata = 0
  - cpu_reset = 1
  - load_done = 0
  - load_err = 0
  - FSM = CNT_HI
- Reset mid-load returns to CNT_HI with address 0. Memory already written is not cleared.
- In ERR, cpu_reset stays 1 permanently (until reset).

## Timing
- All outputs are registered.
- imem_we pulses for exactly one cycle, in the cycle after the DATA_LO byte transfer. In that same cycle, imem_addr/imem_wdata carry that word's address and data.
- Back-to-back bytes (rx_valid held high) are accepted one per cycle with no bubbles. A write pulse can coincide with acceptance of the next DATA_HI byte.
- In the first DONE cycle: cpu_reset falls to 0 and load_done rises to 1 together. This is one cycle after the last byte (checksum, or last DATA_LO without the macro). The last imem write therefore completes no later than the cycle cpu_reset falls.
- load_err rises in the cycle after the offending byte transfer (CNT_LO or CSUM).
- rx_valid low in any receive state stalls the FSM; no timeout.

## Configuration
- S16_LOADER_CHECKSUM_EN defined:
  - The CSUM state exists.
  - The expected byte = 8-bit sum mod 256 of all preceding bytes, including the count bytes.
  - Mismatch → ERR.
- Undefined:
  - No checksum byte is consumed.
  - DONE follows the last word (or CNT_LO when N == 0).
  - ERR is reachable only via oversize N.

## Structure
- Package s16_loader_pkg:
  - FSM state enum.
  - BYTE_W = 8, WORD_W = 16, COUNT_W = 16 constants.
- One sub-module, s16_loader_csum: an 8-bit accumulator with clear and add-enable. It is instantiated only under S16_LOADER_CHECKSUM_EN.

## Test plan
- Macro on, stream 00 02 12 34 AB CD C0 back-to-back → writes 0x1234@0, 0xABCD@1. cpu_reset falls and load_done = 1 one cycle after C0. load_err = 0.
- Same stream with checksum C1 → both writes still occur; load_err = 1, cpu_reset stays 1, rx_ready = 0.
- ADDR_W = 8, count 01 01 (257) → load_err = 1 the cycle after 01 lo byte; no imem_we ever.
- Count 00 00 with checksum 00 (macro on) → DONE with zero writes; macro off → DONE directly after count_lo.
- rx_valid toggling 1/0 every cycle on the first test stream → identical writes and final state, one byte every two cycles.
- reset asserted after the first data word's hi byte, then the full stream resent → clean load from address 0; no stale half-word written.
